// File: rtl/pc_gen_pkg.sv
// pc_gen shared encodings: redirect selects and FSM states.
// Imported by pc_gen, pc_target_calc and the testbench.
package pc_gen_pkg;

  localparam logic [1:0] SEL_BRANCH = 2'b00;
  localparam logic [1:0] SEL_JALR   = 2'b01;
  localparam logic [1:0] SEL_TRAP   = 2'b10;

  localparam logic [1:0] ST_BOOT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  typedef enum logic [1:0] {
    S_BOOT = ST_BOOT,
    S_RUN  = ST_RUN,
    S_HALT = ST_HALT
  } state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: redirect/halt controls in, fetch request out.
// master = pc_gen, slave = instruction memory / control consumer.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            fetch_ready;
  logic            redirect_valid;
  logic [1:0]      redirect_sel;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] trap_vec;
  logic            halt;
  logic            resume;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic [XLEN-1:0] pcplus4;
  logic            misalign_exc;
  logic [1:0]      state;

  modport master (
    input  fetch_ready, redirect_valid, redirect_sel,
    input  br_pc, imm, rs1, trap_vec, halt, resume,
    output pc, pc_valid, pcplus4, misalign_exc, state
  );

  modport slave (
    output fetch_ready, redirect_valid, redirect_sel,
    output br_pc, imm, rs1, trap_vec, halt, resume,
    input  pc, pc_valid, pcplus4, misalign_exc, state
  );
endinterface

// File: rtl/pc_gen_target_calc.sv
// pc_target_calc: combinational redirect target mux/adder with alignment check.
// PC_MISALIGN_TRAP_EN: misaligned branch/jalr targets divert to the trap vector.
module pc_target_calc
  import pc_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] trap_al;

  always_comb begin
    trap_al = trap_vec_i & ~XLEN'(3);
    raw     = br_pc_i + imm_i;
    case (sel_i)
      SEL_JALR: raw = (rs1_i + imm_i) & ~XLEN'(1);
      SEL_TRAP: raw = trap_al;
      default:  raw = br_pc_i + imm_i;
    endcase
`ifdef PC_MISALIGN_TRAP_EN
    misalign_o = (sel_i != SEL_TRAP) && (raw[1:0] != 2'b00);
    target_o   = misalign_o ? trap_al : raw;
`else
    misalign_o = 1'b0;
    target_o   = raw & ~XLEN'(3);
`endif
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with BOOT/RUN/HALT FSM and redirects.
// PC_MISALIGN_TRAP_EN enables trapping on misaligned branch/jalr targets.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              ILEN_BYTES   = 4
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.master bus
);

  state_e          state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcplus4;
  logic [XLEN-1:0] target;
  logic            valid_q;
  logic            exc_q, exc_d;
  logic            mis;
  logic            redir;
  logic            adv;

  pc_target_calc #(.XLEN(XLEN)) u_calc (
    .sel_i      (bus.redirect_sel),
    .br_pc_i    (bus.br_pc),
    .imm_i      (bus.imm),
    .rs1_i      (bus.rs1),
    .trap_vec_i (bus.trap_vec),
    .target_o   (target),
    .misalign_o (mis)
  );

  assign pcplus4 = pc_q + XLEN'(ILEN_BYTES);
  // BOOT swallows redirects; advance only while fetching
  assign redir   = bus.redirect_valid && (state_q != S_BOOT);
  assign adv     = (state_q == S_RUN) && bus.fetch_ready;

  always_comb begin
    pc_d  = pc_q;
    exc_d = 1'b0;
    if (redir) begin
      pc_d  = target;
      exc_d = mis;
    end else if (adv) begin
      pc_d  = pcplus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      exc_q <= exc_d;
      case (state_q)
        S_BOOT: begin
          state_q <= S_RUN;
          valid_q <= 1'b1;
        end
        S_RUN: begin
          if (bus.halt) begin
            state_q <= S_HALT;
            valid_q <= 1'b0;
          end
        end
        S_HALT: begin
          if (bus.resume && !bus.halt) begin
            state_q <= S_RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_valid     = valid_q;
  assign bus.pcplus4      = pcplus4;
  assign bus.misalign_exc = exc_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table, async reset checks, random vs model.
// Expectations follow PC_MISALIGN_TRAP_EN when it is defined.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  pc_gen_if #(.XLEN(32)) bif ();

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .ILEN_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] MB_PC = 32'h100;
  localparam logic [31:0] MB_NX = 32'h104;
  localparam logic [31:0] MJ_PC = 32'h80;
  localparam logic        MEXC  = 1'b1;
`else
  localparam logic [31:0] MB_PC = 32'h20;
  localparam logic [31:0] MB_NX = 32'h24;
  localparam logic [31:0] MJ_PC = 32'h300;
  localparam logic        MEXC  = 1'b0;
`endif

  typedef struct {
    logic        fr;
    logic        rv;
    logic [1:0]  sel;
    logic [31:0] br;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] tv;
    logic        hl;
    logic        rs;
    logic [31:0] epc;
    logic        ev;
    logic [1:0]  est;
    logic        eexc;
  } vec_t;

  vec_t tbl[$];

  logic [1:0]  m_mode;
  logic [31:0] m_pc;
  logic        m_exc;

  function automatic vec_t mk(logic fr, logic rv, logic [1:0] sel,
                              logic [31:0] br, logic [31:0] imm,
                              logic [31:0] rs1, logic [31:0] tv,
                              logic hl, logic rs, logic [31:0] epc,
                              logic ev, logic [1:0] est, logic eexc);
    vec_t v;
    v.fr = fr; v.rv = rv; v.sel = sel; v.br = br; v.imm = imm;
    v.rs1 = rs1; v.tv = tv; v.hl = hl; v.rs = rs;
    v.epc = epc; v.ev = ev; v.est = est; v.eexc = eexc;
    return v;
  endfunction

  task automatic drive(logic fr, logic rv, logic [1:0] sel,
                       logic [31:0] br, logic [31:0] imm,
                       logic [31:0] rs1, logic [31:0] tv,
                       logic hl, logic rs);
    bif.fetch_ready    = fr;
    bif.redirect_valid = rv;
    bif.redirect_sel   = sel;
    bif.br_pc          = br;
    bif.imm            = imm;
    bif.rs1            = rs1;
    bif.trap_vec       = tv;
    bif.halt           = hl;
    bif.resume         = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] epc, logic ev,
                       logic [1:0] est, logic eexc);
    logic [31:0] ep4;
    ep4 = epc + 32'd4;
    n_vec++;
    if (bif.pc !== epc || bif.pc_valid !== ev || bif.state !== est ||
        bif.misalign_exc !== eexc || bif.pcplus4 !== ep4) begin
      n_bad++;
      $display("FAIL %s: got pc=%h v=%b st=%b exc=%b p4=%h, want pc=%h v=%b st=%b exc=%b p4=%h",
               name, bif.pc, bif.pc_valid, bif.state, bif.misalign_exc,
               bif.pcplus4, epc, ev, est, eexc, ep4);
    end
  endtask

  // Reference: state rules applied directly to the current inputs
  task automatic model_step();
    logic [31:0] t;
    logic [31:0] tva;
    logic [1:0]  nm;
    logic        ne;
    nm  = m_mode;
    ne  = 1'b0;
    tva = bif.trap_vec - (bif.trap_vec % 4);
    if (m_mode == ST_BOOT) begin
      nm = ST_RUN;
    end else begin
      if (bif.redirect_valid) begin
        if (bif.redirect_sel == SEL_JALR) begin
          t = bif.rs1 + bif.imm;
          t = t - (t % 2);
        end else if (bif.redirect_sel == SEL_TRAP) begin
          t = tva;
        end else begin
          t = bif.br_pc + bif.imm;
        end
        if (bif.redirect_sel != SEL_TRAP && (t % 4) != 0) begin
`ifdef PC_MISALIGN_TRAP_EN
          m_pc = tva;
          ne   = 1'b1;
`else
          m_pc = t - (t % 4);
`endif
        end else begin
          m_pc = t;
        end
      end else if (m_mode == ST_RUN && bif.fetch_ready) begin
        m_pc = m_pc + 32'd4;
      end
      if (m_mode == ST_RUN && bif.halt)
        nm = ST_HALT;
      else if (m_mode == ST_HALT && bif.resume && !bif.halt)
        nm = ST_RUN;
    end
    m_mode = nm;
    m_exc  = ne;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // fr rv sel br imm rs1 tv hl rs | pc v st exc
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,0, 32'h0,  1,ST_RUN,0));
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,0, 32'h4,  1,ST_RUN,0));
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,0, 32'h8,  1,ST_RUN,0));
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,0, 32'hC,  1,ST_RUN,0));
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,0, 32'h10, 1,ST_RUN,0));
    tbl.push_back(mk(0,0,2'b00,0,0,0,0,0,0, 32'h10, 1,ST_RUN,0));
    tbl.push_back(mk(0,0,2'b00,0,0,0,0,0,0, 32'h10, 1,ST_RUN,0));
    tbl.push_back(mk(0,0,2'b00,0,0,0,0,0,0, 32'h10, 1,ST_RUN,0));
    tbl.push_back(mk(0,1,SEL_BRANCH,32'h8,32'hFFFF_FFF8,0,0,0,0,
                     32'h0, 1,ST_RUN,0));
    tbl.push_back(mk(1,1,SEL_JALR,0,32'h4,32'h1001,0,0,0,
                     32'h1004, 1,ST_RUN,0));
    tbl.push_back(mk(1,1,SEL_BRANCH,32'h20,32'h2,0,32'h100,0,0,
                     MB_PC, 1,ST_RUN,MEXC));
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,0, MB_NX, 1,ST_RUN,0));
    tbl.push_back(mk(1,1,SEL_BRANCH,32'h40,0,0,0,0,0, 32'h40, 1,ST_RUN,0));
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,1,0, 32'h44, 0,ST_HALT,0));
    tbl.push_back(mk(1,1,SEL_TRAP,0,0,0,32'h203,0,0, 32'h200,0,ST_HALT,0));
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,0, 32'h200, 0,ST_HALT,0));
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,1, 32'h200, 1,ST_RUN,0));
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,0, 32'h204, 1,ST_RUN,0));
    tbl.push_back(mk(0,0,2'b00,0,0,0,0,0,1, 32'h204, 1,ST_RUN,0));
    tbl.push_back(mk(0,0,2'b00,0,0,0,0,1,0, 32'h204, 0,ST_HALT,0));
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,1,1, 32'h204, 0,ST_HALT,0));
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,1, 32'h204, 1,ST_RUN,0));
    tbl.push_back(mk(1,1,SEL_JALR,0,0,32'h302,32'h80,0,0,
                     MJ_PC, 1,ST_RUN,MEXC));
    tbl.push_back(mk(0,1,SEL_BRANCH,32'h500,0,0,0,1,0, 32'h500,0,ST_HALT,0));
    tbl.push_back(mk(0,0,2'b00,0,0,0,0,0,1, 32'h500, 1,ST_RUN,0));
    tbl.push_back(mk(0,1,SEL_BRANCH,32'hFFFF_FFF0,32'hC,0,0,0,0,
                     32'hFFFF_FFFC, 1,ST_RUN,0));
    tbl.push_back(mk(1,0,2'b00,0,0,0,0,0,0, 32'h0, 1,ST_RUN,0));
    tbl.push_back(mk(1,1,2'b11,32'h10,32'h10,0,0,0,0, 32'h20, 1,ST_RUN,0));

    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'h0, 1'b0, ST_BOOT, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].fr, tbl[i].rv, tbl[i].sel, tbl[i].br, tbl[i].imm,
            tbl[i].rs1, tbl[i].tv, tbl[i].hl, tbl[i].rs);
      tick();
      check($sformatf("vec%0d", i), tbl[i].epc, tbl[i].ev,
            tbl[i].est, tbl[i].eexc);
    end

    // Async reset between edges with a redirect pending
    drive(1, 1, SEL_BRANCH, 32'h700, 0, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 32'h0, 1'b0, ST_BOOT, 1'b0);
    #1;
    rst = 1'b0;
    tick();
    check("boot_ignores_redirect", 32'h0, 1'b1, ST_RUN, 1'b0);

    m_mode = ST_RUN;
    m_pc   = 32'h0;
    m_exc  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 10) < 7,
            ($urandom % 10) < 2,
            2'($urandom % 4),
            $urandom,
            (($urandom % 2) == 0) ? 32'($urandom % 16) : $urandom,
            $urandom,
            $urandom,
            ($urandom % 10) < 1,
            ($urandom % 10) < 3);
      model_step();
      tick();
      check("rand", m_pc, m_mode == ST_RUN, m_mode, m_exc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator, successor to the single-cycle PC register.
- Widened to XLEN; reset and trap vectors are parameters.
- Adds a valid/ready fetch handshake with stall, and three redirect modes: branch, JALR and trap.
- Adds a halt/resume state machine and misaligned-target detection.
- Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
- XLEN, 32, datapath and PC width in bits (legal values: 32, 64).
- RESET_VECTOR, 0, PC value loaded on reset.
- ILEN_BYTES, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_ready  in  1  instruction memory accepts the current pc this cycle.
- redirect_valid  in  1  apply a redirect this cycle.
- redirect_sel  in  2  00 branch, 01 jalr, 10 trap, 11 reserved (treated as branch).
- br_pc  in  XLEN  PC of the branch/jump instruction.
- imm  in  XLEN  sign-extended immediate.
- rs1  in  XLEN  JALR base register value.
- trap_vec  in  XLEN  trap handler address (mtvec).
- halt  in  1  request to stop fetching.
- resume  in  1  leave HALT.
- pc  out  XLEN  current fetch address.
- pc_valid  out  1  pc is a valid fetch request.
- pcplus4  out  XLEN  pc + ILEN_BYTES, combinational.
- misalign_exc  out  1  one-cycle pulse: misaligned target detected.
- state  out  2  00 BOOT, 01 RUN, 10 HALT.

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc = RESET_VECTOR, state = BOOT, pc_valid = 0, misalign_exc = 0.
  - Any pending redirect is discarded.
- State machine:
  - BOOT: one cycle with pc_valid = 0, so memory can settle after reset. Next state is always RUN. A redirect is ignored in BOOT.
  - RUN: pc_valid = 1.
  - HALT: pc_valid = 0. pc holds its value.
- Target computation, in XLEN-bit arithmetic with wrap modulo 2^XLEN and no overflow flag:
  - branch = br_pc + imm.
  - jalr = (rs1 + imm) with bit 0 cleared.
  - trap = trap_vec with bits [1:0] cleared.
- Next-pc priority, highest first:
  1. rst.
  2. redirect_valid (in RUN or HALT): pc <= target at the next edge, regardless of fetch_ready. Latency is one cycle: redirect at edge N, target on pc after edge N.
  3. RUN && fetch_ready: pc <= pcplus4.
  4. Otherwise pc holds (stall).
- Stall: pc and pc_valid stay stable while fetch_ready = 0 (valid must not drop without a redirect).
- Halt:
  - halt in RUN -> HALT at the next edge.
  - A redirect in the same cycle as halt is still applied.
  - A sequential advance in the same cycle as halt is applied only if fetch_ready = 1 (that fetch is already accepted).
- Resume:
  - resume in HALT -> RUN at the next edge.
  - halt and resume asserted together in HALT: stay in HALT.
  - resume outside HALT is ignored.
- Redirects in HALT update pc but do not leave HALT.
- Misalignment: target bits [1:0] != 0 on a branch or jalr redirect is misaligned. Handling depends on PC_MISALIGN_TRAP_EN (see below).
- pcplus4 wraps, e.g. 0xFFFF_FFFC -> 0x0000_0000 for XLEN = 32.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned branch/jalr target is not loaded; pc <= trap_vec with bits [1:0] cleared.
  - misalign_exc pulses for one cycle, aligned with the new pc.
  - A trap redirect never raises misalign_exc.
- Undefined:
  - Target bits [1:0] are forced to 0 and loaded.
  - misalign_exc is tied to 0.

Decomposition:
- Shared package holds:
  - localparams for the redirect_sel encodings: SEL_BRANCH, SEL_JALR, SEL_TRAP.
  - localparams for the state encodings: ST_BOOT, ST_RUN, ST_HALT.
- One sub-module is natural: pc_target_calc, a combinational target mux/adder with the alignment check, reusable by the branch unit.
- The FSM and PC register stay in pc_gen.

Test Plan:
1. Reset and sequential advance:
   - Stimulus: rst pulse, fetch_ready = 1.
   - Required: pc = 0 with pc_valid = 0 for one cycle (BOOT). Then pc_valid = 1 and pc steps 0 -> 4 -> 8 -> 0xC on successive edges.
2. Stall, then branch:
   - Stimulus: at pc = 0x10, fetch_ready = 0 for 3 cycles, then redirect_valid with branch, br_pc = 0x8, imm = 0xFFFF_FFF8.
   - Required: pc holds 0x10 during the stall, then becomes 0x0 one edge after the redirect.
3. JALR:
   - Stimulus: rs1 = 0x1001, imm = 0x4, sel = jalr.
   - Required: pc = 0x1004 (bit 0 cleared) and misalign_exc = 0.
4. Misaligned branch:
   - Stimulus: br_pc = 0x20, imm = 0x2, trap_vec = 0x100.
   - Required with PC_MISALIGN_TRAP_EN: pc = 0x100 and misalign_exc pulses for 1 cycle.
   - Required without it: pc = 0x20.
5. Halt/resume:
   - Stimulus: halt at pc = 0x40 with fetch_ready = 1, then a trap redirect to 0x200 while halted, then resume.
   - Required: pc = 0x44 with pc_valid = 0 while halted; pc = 0x200 with state still HALT; after resume, pc_valid = 1 at 0x200.
6. Mid-operation reset and wrap:
   - Stimulus: assert rst asynchronously between edges during RUN.
   - Required: pc = RESET_VECTOR and state = BOOT immediately.
   - Separately, redirect to 0xFFFF_FFFC: the next advance gives pc = 0x0.
